// File: rtl/multi_tick_divider_pkg.sv
// Shared types and helpers for the multi-channel tick divider.
package multi_tick_pkg;

    // Channel output mode: square wave or one-cycle strobe.
    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // Channel-index width; a single channel still needs a 1-bit index port.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_tick_divider_div_channel.sv
// One divider channel: programmable divisor, toggle/pulse output, fully registered.
module div_channel
    import multi_tick_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter int unsigned DEFAULT_DIV  = 300000000,
    parameter logic        DEFAULT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             ch_wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic             tick,
    output logic             out
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
    localparam mode_e            RST_MODE = mode_e'(DEFAULT_MODE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    mode_e            mode_q, mode_d;
    logic             tgl_q, tgl_d;
    logic             tick_q, tick_d;
    logic             out_q, out_d;
    logic             terminal;

    // Next-state: write > sync clear > idle divisor > hold > terminal > count.
    // cnt stays below div, so div-1 never underflows when div is nonzero.
    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        mode_d   = mode_q;
        tgl_d    = tgl_q;
        tick_d   = 1'b0;
        terminal = (cnt_q == div_q - ONE);
        if (ch_wr) begin
            div_d  = wr_div;
            mode_d = mode_e'(wr_mode);
            cnt_d  = '0;
            tgl_d  = 1'b0;
        end else if (sync_clr || (div_q == '0)) begin
            cnt_d = '0;
            tgl_d = 1'b0;
        end else if (en) begin
            if (terminal) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                tgl_d  = ~tgl_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
        // out is registered from the post-edge mode/tick/tgl so it never lags them.
        out_d = (mode_d == MODE_PULSE) ? tick_d : tgl_d;
    end

    // Channel state registers with async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            div_q  <= RST_DIV;
            mode_q <= RST_MODE;
            tgl_q  <= 1'b0;
            tick_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            mode_q <= mode_d;
            tgl_q  <= tgl_d;
            tick_q <= tick_d;
            out_q  <= out_d;
        end
    end

    assign tick = tick_q;
    assign out  = out_q;

endmodule

// File: rtl/multi_tick_divider.sv
// Multi-channel clock-enable / square-wave generator: write decode plus channel array.
module multi_tick_divider
    import multi_tick_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int unsigned DEFAULT_DIV  = 300000000,
    parameter logic        DEFAULT_MODE = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          sync_clr,
    input  logic                          wr_en,
    input  logic [ch_width(NUM_CH)-1:0]   wr_ch,
    input  logic [CNT_W-1:0]              wr_div,
    input  logic                          wr_mode,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             out
);

    logic [NUM_CH-1:0] ch_wr;

    // One-hot write decode; an index with no matching channel selects nothing.
    always_comb begin
        ch_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i] = wr_en && (int'(wr_ch) == i);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        div_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_MODE (DEFAULT_MODE)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .sync_clr (sync_clr),
            .ch_wr    (ch_wr[g]),
            .wr_div   (wr_div),
            .wr_mode  (wr_mode),
            .tick     (tick[g]),
            .out      (out[g])
        );
    end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Bench for multi_tick_divider: directed vector table, corner sequences, random vs model.
module tb_multi_tick_divider;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DDIV = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          sync_clr = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_mode = 1'b0;
    logic [1:0]    wr_ch = '0;
    logic [CW-1:0] wr_div = '0;
    logic [NCH-1:0] tick, out;
    logic [2:0]    tick3, out3;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    multi_tick_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV), .DEFAULT_MODE(1'b0)) u_dut (
        .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode), .tick(tick), .out(out)
    );

    // Three-channel copy: index 3 is out of range for it.
    multi_tick_divider #(.NUM_CH(3), .CNT_W(CW), .DEFAULT_DIV(DDIV), .DEFAULT_MODE(1'b0)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode), .tick(tick3), .out(out3)
    );

    // Reference model: enabled cycles elapsed since last restart per channel.
    int m_e    [NCH];
    int m_div  [NCH];
    bit m_mode [NCH];
    bit m_tick [NCH];

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_e[c] = 0; m_div[c] = DDIV; m_mode[c] = 1'b0; m_tick[c] = 1'b0;
        end
    endfunction

    function automatic void model_update();
        for (int c = 0; c < NCH; c++) begin
            if (wr_en && int'(wr_ch) == c) begin
                m_div[c] = int'(wr_div); m_mode[c] = wr_mode; m_e[c] = 0; m_tick[c] = 1'b0;
            end else if (sync_clr || m_div[c] == 0) begin
                m_e[c] = 0; m_tick[c] = 1'b0;
            end else if (!en) begin
                m_tick[c] = 1'b0;
            end else begin
                m_e[c]++;
                m_tick[c] = (m_e[c] % m_div[c]) == 0;
            end
        end
    endfunction

    function automatic logic [NCH-1:0] exp_tick();
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = m_tick[c];
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_out();
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) begin
            if (m_mode[c]) r[c] = m_tick[c];
            else           r[c] = (m_div[c] != 0) && (((m_e[c] / m_div[c]) % 2) == 1);
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock edge: advance model, then compare both DUTs against it.
    task automatic step(input string nm);
        logic [NCH-1:0] et, eo;
        @(posedge clk);
        model_update();
        #1;
        et = exp_tick();
        eo = exp_out();
        check({nm, ".tick"},  tick, et);
        check({nm, ".out"},   out,  eo);
        check({nm, ".tick3"}, {1'b0, tick3}, {1'b0, et[2:0]});
        check({nm, ".out3"},  {1'b0, out3},  {1'b0, eo[2:0]});
    endtask

    typedef struct {
        logic       wr_en;
        logic [1:0] wr_ch;
        logic [7:0] wr_div;
        logic       wr_mode;
        logic       en;
        logic       clr;
        logic [3:0] xt;
        logic [3:0] xo;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [1:0] ch, input logic [7:0] d,
                                input logic m, input logic e, input logic c,
                                input logic [3:0] xt, input logic [3:0] xo);
        vec_t v;
        v.wr_en = w; v.wr_ch = ch; v.wr_div = d; v.wr_mode = m;
        v.en = e; v.clr = c; v.xt = xt; v.xo = xo;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Default-divisor start: ticks on edges 5 and 10, toggle out high in between.
        for (int i = 0; i < 10; i++)
            tbl[i] = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0,
                        (i == 4 || i == 9) ? 4'hF : 4'h0,
                        (i >= 4 && i < 9) ? 4'hF : 4'h0);
        // Write ch2 div=3 PULSE at edge 11; ch2 strobes 3 edges later, others untouched.
        tbl[10] = mk(1'b1, 2'd2, 8'd3, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        tbl[11] = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        tbl[12] = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        tbl[13] = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0100);

        model_reset();
        #2;
        check("reset.tick", tick, 4'h0);
        check("reset.out",  out,  4'h0);
        #5 reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            wr_en = tbl[i].wr_en; wr_ch = tbl[i].wr_ch; wr_div = tbl[i].wr_div;
            wr_mode = tbl[i].wr_mode; en = tbl[i].en; sync_clr = tbl[i].clr;
            step("vec");
            check($sformatf("tbl%0d.tick", i), tick, tbl[i].xt);
            check($sformatf("tbl%0d.out", i),  out,  tbl[i].xo);
        end
        wr_en = 1'b0;

        // ch1 div=1 TOGGLE: tick every edge, out alternates starting high.
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd1; wr_mode = 1'b0;
        step("wr_d1");
        wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step("d1");
            check("d1.tick1", {3'b0, tick[1]}, 4'd1);
            check("d1.out1",  {3'b0, out[1]},  (k % 2 == 0) ? 4'd1 : 4'd0);
        end

        // ch1 div=0: channel idle.
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd0; wr_mode = 1'b0;
        step("wr_d0");
        wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("d0");
            check("d0.tick1", {3'b0, tick[1]}, 4'd0);
            check("d0.out1",  {3'b0, out[1]},  4'd0);
        end

        // Write on ch0's terminal-count edge suppresses the tick.
        sync_clr = 1'b1;
        step("clr_a");
        check("clr.tick", tick, 4'h0);
        check("clr.out",  out,  4'h0);
        sync_clr = 1'b0;
        for (int k = 0; k < 4; k++) step("pre_term");
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd5; wr_mode = 1'b0;
        step("wr_term");
        check("wr_term.tick0", {3'b0, tick[0]}, 4'd0);
        check("wr_term.tick3", {3'b0, tick[3]}, 4'd1);
        wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step("post_term");
            check("post_term.tick0", {3'b0, tick[0]}, 4'd0);
        end
        step("term_tick");
        check("term_tick.tick0", {3'b0, tick[0]}, 4'd1);

        // en low for two cycles stretches the period by two.
        sync_clr = 1'b1;
        step("clr_b");
        sync_clr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            en = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            step("gap");
            check("gap.tick0", {3'b0, tick[0]}, 4'd0);
        end
        en = 1'b1;
        step("gap_tick");
        check("gap_tick.tick0", {3'b0, tick[0]}, 4'd1);

        // Async reset pulse between edges clears outputs immediately.
        sync_clr = 1'b1;
        step("clr_c");
        sync_clr = 1'b0;
        for (int k = 0; k < 5; k++) step("pre_rst");
        check("pre_rst.out0", {3'b0, out[0]}, 4'd1);
        #3 reset = 1'b0;
        #1;
        check("async_rst.tick", tick, 4'h0);
        check("async_rst.out",  out,  4'h0);
        check("async_rst.out3", {1'b0, out3}, 4'h0);
        model_reset();
        #1 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step("post_rst");
            check("post_rst.tick", tick, 4'h0);
        end
        step("post_rst5");
        check("post_rst5.tick", tick, 4'hF);

        // Index 3 is out of range for the three-channel instance.
        wr_en = 1'b1; wr_ch = 2'd3; wr_div = 8'd1; wr_mode = 1'b1;
        step("oor_wr");
        check("oor_wr.tick3", {1'b0, tick3}, 4'h0);
        wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("oor");
            check("oor.tick3",     {1'b0, tick3}, 4'h0);
            check("oor.main_tick", {3'b0, tick[3]}, 4'd1);
        end
        step("oor_tick");
        check("oor_tick.tick3", {1'b0, tick3}, 4'b0111);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            wr_en    = ($urandom_range(0, 7) == 0);
            wr_ch    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       wr_div = 8'd0;
                1:       wr_div = 8'd1;
                2:       wr_div = 8'd2;
                default: wr_div = 8'($urandom_range(1, 12));
            endcase
            wr_mode  = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 7) != 0);
            sync_clr = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
